// File: rtl/vram_host_arbiter.sv
// Shares one synchronous VRAM port between the VDP (dlclk=1 slots) and a host engine (dlclk=0 slots).
// Host writes are posted through a small FIFO; reads wait for the FIFO to drain and return two edges after issue.
module vram_host_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk21m,
    input  logic        reset,
    input  logic        vdp_dlclk,
    input  logic [16:0] vdp_a,
    input  logic        vdp_we_n,
    input  logic [7:0]  vdp_do,
    output logic [15:0] vdp_di,
    input  logic        host_wr,
    input  logic        host_rd,
    input  logic [16:0] host_addr,
    input  logic [7:0]  host_din,
    output logic        host_busy,
    output logic        host_rd_valid,
    output logic [7:0]  host_dout,
    output logic [15:0] VRAM_address,
    output logic [7:0]  VRAM_do,
    output logic        VRAM_we_lo,
    output logic        VRAM_we_hi,
    input  logic [7:0]  VRAM_di_lo,
    input  logic [7:0]  VRAM_di_hi
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_PEND = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  dat;
    } wr_entry_t;

    wr_entry_t   fifo_mem_q [FIFO_DEPTH];
    wr_entry_t   fifo_mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    rd_state_e   rd_state_q, rd_state_d;
    logic [16:0] rd_addr_q, rd_addr_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  dout_q, dout_d;

    logic      fifo_full;
    logic      fifo_empty;
    logic      host_slot;
    logic      push;
    logic      pop;
    logic      rd_accept;
    logic      rd_issue;
    wr_entry_t head;

    always_comb begin
        fifo_full  = (level_q == LW'(FIFO_DEPTH));
        fifo_empty = (level_q == '0);
        host_slot  = ~vdp_dlclk;
        head       = fifo_mem_q[rd_ptr_q];
        // A write command in the same cycle always wins; the read is simply dropped.
        push       = host_wr & ~fifo_full & (rd_state_q == R_IDLE);
        pop        = host_slot & ~fifo_empty;
        rd_accept  = host_rd & ~host_wr & (rd_state_q == R_IDLE);
        rd_issue   = host_slot & fifo_empty & (rd_state_q == R_PEND);
    end

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = '{addr: host_addr, dat: host_din};
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_valid_d = 1'b0;
        dout_d     = dout_q;
        case (rd_state_q)
            R_IDLE: begin
                if (rd_accept) begin
                    rd_addr_d  = host_addr;
                    rd_state_d = R_PEND;
                end
            end
            R_PEND: begin
                if (rd_issue) begin
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                // RAM output now reflects the address presented on the issue cycle.
                dout_d     = rd_addr_q[16] ? VRAM_di_hi : VRAM_di_lo;
                rd_valid_d = 1'b1;
                rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            fifo_mem_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_state_q <= R_IDLE;
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            dout_q     <= 8'h00;
        end else begin
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_valid_q <= rd_valid_d;
            dout_q     <= dout_d;
        end
    end

    always_comb begin
        VRAM_address = vdp_a[15:0];
        VRAM_do      = vdp_do;
        VRAM_we_lo   = 1'b0;
        VRAM_we_hi   = 1'b0;
        if (vdp_dlclk) begin
            VRAM_we_lo = ~vdp_we_n & ~vdp_a[16];
            VRAM_we_hi = ~vdp_we_n &  vdp_a[16];
        end else if (pop) begin
            VRAM_address = head.addr[15:0];
            VRAM_do      = head.dat;
            VRAM_we_lo   = ~head.addr[16];
            VRAM_we_hi   =  head.addr[16];
        end else if (rd_state_q == R_PEND) begin
            VRAM_address = rd_addr_q[15:0];
        end
        if (reset) begin
            VRAM_we_lo = 1'b0;
            VRAM_we_hi = 1'b0;
        end
    end

    assign vdp_di        = {VRAM_di_hi, VRAM_di_lo};
    assign host_busy     = fifo_full | (rd_state_q != R_IDLE);
    assign host_rd_valid = rd_valid_q;
    assign host_dout     = dout_q;

endmodule

// File: tb/tb_vram_host_arbiter.sv
// Bench for vram_host_arbiter: directed scenarios plus random traffic against a queue/array reference model.
module tb_vram_host_arbiter;

    localparam int DEPTH = 4;

    logic        clk21m = 1'b0;
    logic        reset;
    logic        vdp_dlclk;
    logic [16:0] vdp_a;
    logic        vdp_we_n;
    logic [7:0]  vdp_do;
    logic [15:0] vdp_di;
    logic        host_wr, host_rd;
    logic [16:0] host_addr;
    logic [7:0]  host_din;
    logic        host_busy, host_rd_valid;
    logic [7:0]  host_dout;
    logic [15:0] VRAM_address;
    logic [7:0]  VRAM_do;
    logic        VRAM_we_lo, VRAM_we_hi;
    logic [7:0]  VRAM_di_lo = 8'h00;
    logic [7:0]  VRAM_di_hi = 8'h00;

    always #5 clk21m = ~clk21m;

    vram_host_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk21m(clk21m), .reset(reset), .vdp_dlclk(vdp_dlclk), .vdp_a(vdp_a),
        .vdp_we_n(vdp_we_n), .vdp_do(vdp_do), .vdp_di(vdp_di),
        .host_wr(host_wr), .host_rd(host_rd), .host_addr(host_addr), .host_din(host_din),
        .host_busy(host_busy), .host_rd_valid(host_rd_valid), .host_dout(host_dout),
        .VRAM_address(VRAM_address), .VRAM_do(VRAM_do), .VRAM_we_lo(VRAM_we_lo),
        .VRAM_we_hi(VRAM_we_hi), .VRAM_di_lo(VRAM_di_lo), .VRAM_di_hi(VRAM_di_hi)
    );

    // Synchronous VRAM: two 64K byte banks, read data one cycle after address.
    logic [7:0] ram_lo [65536];
    logic [7:0] ram_hi [65536];
    always @(posedge clk21m) begin
        if (VRAM_we_lo) ram_lo[VRAM_address] <= VRAM_do;
        if (VRAM_we_hi) ram_hi[VRAM_address] <= VRAM_do;
        VRAM_di_lo <= ram_lo[VRAM_address];
        VRAM_di_hi <= ram_hi[VRAM_address];
    end

    // Reference model: flat 128K byte memory, posted-write queue, read phase 0=idle 1=waiting 2=fetched.
    typedef struct {
        logic [16:0] a;
        logic [7:0]  d;
    } ent_t;
    logic [7:0]  mref [131072];
    ent_t        mq [$];
    int          m_ph;
    logic [16:0] m_ra;
    logic [7:0]  m_rdat;
    logic        m_valid;
    logic [7:0]  m_dout;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_seen = 0;
    int rdv_seen = 0;
    logic [15:0] last_addr;
    logic [7:0]  last_do, last_dout;
    logic        last_lo, last_hi, last_busy, last_rdv;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    function automatic void mclear();
        mq.delete();
        m_ph    = 0;
        m_valid = 1'b0;
        m_dout  = 8'h00;
    endfunction

    function automatic void mstep();
        bit   slot = !vdp_dlclk;
        bit   full = (mq.size() == DEPTH);
        int   ph   = m_ph;
        ent_t e;
        m_valid = (ph == 2);
        if (ph == 2) m_dout = m_rdat;
        if (vdp_dlclk && !vdp_we_n) mref[vdp_a] = vdp_do;
        if (ph == 1 && slot && mq.size() == 0) begin
            m_rdat = mref[m_ra];
            m_ph   = 2;
        end else if (ph == 2) begin
            m_ph = 0;
        end
        if (slot && mq.size() > 0) begin
            mref[mq[0].a] = mq[0].d;
            void'(mq.pop_front());
        end
        if (host_wr && !full && ph == 0) begin
            e.a = host_addr;
            e.d = host_din;
            mq.push_back(e);
        end else if (host_rd && !host_wr && ph == 0) begin
            m_ra = host_addr;
            m_ph = 1;
        end
    endfunction

    // Called at a negedge with inputs already set; checks outputs, advances one edge, returns at next negedge.
    task automatic tick();
        logic [16:0] ea;
        logic [7:0]  ed;
        logic        el, eh;
        if (reset) mclear();
        ea = vdp_a;
        ed = vdp_do;
        el = 1'b0;
        eh = 1'b0;
        if (vdp_dlclk) begin
            el = ~vdp_we_n & ~vdp_a[16];
            eh = ~vdp_we_n & vdp_a[16];
        end else if (mq.size() > 0) begin
            ea = mq[0].a;
            ed = mq[0].d;
            el = ~ea[16];
            eh = ea[16];
        end else if (m_ph == 1) begin
            ea = m_ra;
        end
        if (reset) begin
            el = 1'b0;
            eh = 1'b0;
        end
        #1;
        chk("vram_address", 32'(VRAM_address), 32'(ea[15:0]));
        if (el || eh || vdp_dlclk) chk("vram_do", 32'(VRAM_do), 32'(ed));
        chk("we_lo", 32'(VRAM_we_lo), 32'(el));
        chk("we_hi", 32'(VRAM_we_hi), 32'(eh));
        chk("host_busy", 32'(host_busy), 32'((mq.size() == DEPTH) || (m_ph != 0)));
        chk("rd_valid", 32'(host_rd_valid), 32'(m_valid));
        chk("host_dout", 32'(host_dout), 32'(m_dout));
        chk("vdp_di", 32'(vdp_di), 32'({VRAM_di_hi, VRAM_di_lo}));
        last_addr = VRAM_address;
        last_do   = VRAM_do;
        last_lo   = VRAM_we_lo;
        last_hi   = VRAM_we_hi;
        last_busy = host_busy;
        last_rdv  = host_rd_valid;
        last_dout = host_dout;
        if (!vdp_dlclk && (VRAM_we_lo || VRAM_we_hi)) wr_seen++;
        if (host_rd_valid) rdv_seen++;
        @(posedge clk21m);
        if (reset) mclear();
        else mstep();
        @(negedge clk21m);
    endtask

    task automatic drv(input logic dl, input logic wr, input logic rd,
                       input logic [16:0] a, input logic [7:0] d);
        vdp_dlclk = dl;
        vdp_we_n  = 1'b1;
        host_wr   = wr;
        host_rd   = rd;
        host_addr = a;
        host_din  = d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drv(1'b0, 1'b0, 1'b0, 17'h0, 8'h0);
            tick();
        end
    endtask

    initial begin
        int base_w, base_r;
        logic [7:0] got_dout;
        for (int i = 0; i < 65536; i++) begin
            ram_lo[i] = 8'h00;
            ram_hi[i] = 8'h00;
        end
        for (int i = 0; i < 131072; i++) mref[i] = 8'h00;
        mclear();
        m_ra = '0;
        m_rdat = '0;
        reset = 1'b1;
        vdp_a = 17'h1FFFF;
        vdp_do = 8'h77;
        drv(1'b1, 1'b0, 1'b0, 17'h0, 8'h0);
        vdp_we_n = 1'b0;
        @(negedge clk21m);

        // Reset: VDP write strobe must be masked, host outputs idle.
        tick();
        chk("rst_we_hi", 32'(last_hi), 32'd0);
        chk("rst_busy", 32'(last_busy), 32'd0);
        chk("rst_dout", 32'(last_dout), 32'h00);
        reset = 1'b0;
        vdp_a = 17'h00005;
        idle(2);
        chk("no_access_after_reset", 32'(wr_seen), 32'd0);

        // Three posted writes interleaved with VDP slots.
        drv(1'b1, 1'b1, 1'b0, 17'h00010, 8'h11); tick();
        drv(1'b0, 1'b1, 1'b0, 17'h10020, 8'h22); tick();
        chk("w1_we_lo", 32'({last_lo, last_hi}), 32'b10);
        chk("w1_addr", 32'(last_addr), 32'h0010);
        chk("w1_do", 32'(last_do), 32'h11);
        drv(1'b1, 1'b1, 1'b0, 17'h00030, 8'h33); tick();
        chk("vdp_slot_no_we", 32'({last_lo, last_hi}), 32'b00);
        drv(1'b0, 1'b0, 1'b0, 17'h0, 8'h0); tick();
        chk("w2_we_hi", 32'({last_lo, last_hi}), 32'b01);
        chk("w2_addr", 32'(last_addr), 32'h0020);
        chk("w2_do", 32'(last_do), 32'h22);
        drv(1'b1, 1'b0, 1'b0, 17'h0, 8'h0); tick();
        drv(1'b0, 1'b0, 1'b0, 17'h0, 8'h0); tick();
        chk("w3_we_lo", 32'({last_lo, last_hi}), 32'b10);
        chk("w3_addr", 32'(last_addr), 32'h0030);
        chk("w3_do", 32'(last_do), 32'h33);
        idle(2);

        // Five writes while the VDP owns the bus: fifth is dropped.
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 1'b1, 1'b0, 17'h00040 + 17'(i), 8'h40 + 8'(i));
            tick();
        end
        chk("full_busy", 32'(last_busy), 32'd1);
        base_w = wr_seen;
        idle(6);
        chk("full_drain_count", 32'(wr_seen - base_w), 32'd4);

        // VDP hi-bank write while the FIFO holds one entry.
        drv(1'b1, 1'b1, 1'b0, 17'h00050, 8'h55); tick();
        drv(1'b1, 1'b0, 1'b0, 17'h0, 8'h0);
        vdp_a = 17'h1FFFF;
        vdp_do = 8'h5A;
        vdp_we_n = 1'b0;
        tick();
        chk("vdp_hi_only", 32'({last_lo, last_hi}), 32'b01);
        chk("vdp_hi_addr", 32'(last_addr), 32'hFFFF);
        base_w = wr_seen;
        idle(3);
        chk("fifo_level_kept", 32'(wr_seen - base_w), 32'd1);

        // Read-after-write coherence.
        drv(1'b0, 1'b1, 1'b0, 17'h10100, 8'hA5); tick();
        drv(1'b0, 1'b0, 1'b1, 17'h10100, 8'h00); tick();
        base_r = rdv_seen;
        got_dout = 8'h00;
        for (int k = 0; k < 10; k++) begin
            drv(1'b0, 1'b0, 1'b0, 17'h0, 8'h0);
            tick();
            if (last_rdv) got_dout = last_dout;
        end
        chk("raw_rdv_count", 32'(rdv_seen - base_r), 32'd1);
        chk("raw_dout", 32'(got_dout), 32'hA5);

        // Simultaneous write and read: read dropped.
        base_r = rdv_seen;
        drv(1'b0, 1'b1, 1'b1, 17'h00200, 8'h3C); tick();
        idle(6);
        chk("wr_rd_same_no_rdv", 32'(rdv_seen - base_r), 32'd0);

        // Reset while a read waits behind two posted writes.
        drv(1'b1, 1'b1, 1'b0, 17'h00300, 8'h01); tick();
        drv(1'b1, 1'b1, 1'b0, 17'h10300, 8'h02); tick();
        drv(1'b1, 1'b0, 1'b1, 17'h00300, 8'h00); tick();
        drv(1'b1, 1'b0, 1'b0, 17'h0, 8'h0); tick();
        chk("pend_busy", 32'(last_busy), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_busy", 32'(last_busy), 32'd0);
        chk("mid_rst_rdv", 32'(last_rdv), 32'd0);
        reset = 1'b0;
        base_w = wr_seen;
        base_r = rdv_seen;
        idle(6);
        chk("rst_discard_writes", 32'(wr_seen - base_w), 32'd0);
        chk("rst_discard_read", 32'(rdv_seen - base_r), 32'd0);

        // Random traffic over a small address window so reads hit earlier writes.
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 399) == 0);
            vdp_dlclk = $urandom_range(0, 1) == 1;
            vdp_a     = {1'($urandom_range(0, 1)), 12'h000, 4'($urandom_range(0, 15))};
            vdp_do    = 8'($urandom);
            vdp_we_n  = ($urandom_range(0, 2) != 0);
            host_wr   = ($urandom_range(0, 3) == 0);
            host_rd   = ($urandom_range(0, 4) == 0);
            host_addr = {1'($urandom_range(0, 1)), 12'h000, 4'($urandom_range(0, 15))};
            host_din  = 8'($urandom);
            tick();
        end
        reset = 1'b0;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
